line_cmd_scheduler: RTL

Front-end controller for the Bresenham line engine. It arbitrates draw and clear commands from NUM_REQ requesters using round-robin, then latches the winning command. It sequences the engine's start/reset_buff/done protocol, including the engine's clear-and-exit handshake. It also guards each draw with a watchdog and sits between the command sources (host interface, rasteriser front end) and the single shared engine.

---
 rtl/gpu_ctrl_pkg.sv | 28 ++
 rtl/line_cmd_scheduler_if.sv | 28 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/line_cmd_scheduler.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/gpu_ctrl_pkg.sv
// Shared types and defaults for the line-engine command scheduler.
package gpu_ctrl_pkg;

  localparam int COORD_W_DEF    = 8;
  localparam int CLR_CYCLES_DEF = 2;
  localparam int TIMEOUT_DEF    = 1024;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_CLR_ASSERT,
    S_CLR_HOLD,
    S_CLR_EXIT,
    S_CLR_SETTLE,
    S_COMPLETE,
    S_HALT
  } sched_state_t;

  typedef struct packed {
    logic                   clear;
    logic [COORD_W_DEF-1:0] x0;
    logic [COORD_W_DEF-1:0] y0;
    logic [COORD_W_DEF-1:0] x1;
    logic [COORD_W_DEF-1:0] y1;
  } line_cmd_t;

endpackage

// File: rtl/line_cmd_scheduler_if.sv
// Requester command bus plus the engine control/endpoint signals.
// master = requesters and engine, slave = scheduler.
interface line_cmd_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int COORD_W = 8
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_clear;
  logic [NUM_REQ*4*COORD_W-1:0] req_coord;
  logic [NUM_REQ-1:0]           req_ready;
  logic [COORD_W-1:0]           eng_x0;
  logic [COORD_W-1:0]           eng_y0;
  logic [COORD_W-1:0]           eng_x1;
  logic [COORD_W-1:0]           eng_y1;
  logic                         eng_start;
  logic                         eng_reset_buff;
  logic                         eng_done;

  modport master (
    output req_valid, req_clear, req_coord, eng_done,
    input  req_ready, eng_x0, eng_y0, eng_x1, eng_y1, eng_start, eng_reset_buff
  );

  modport slave (
    input  req_valid, req_clear, req_coord, eng_done,
    output req_ready, eng_x0, eng_y0, eng_x1, eng_y1, eng_start, eng_reset_buff
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  // Walk requesters starting at ptr; the first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end
endmodule

// File: rtl/line_cmd_scheduler.sv
// Arbitrates draw/clear commands and sequences the shared line engine.
//
// state        | meaning
// IDLE         | accepting commands
// ISSUE        | eng_start pulse for a draw
// WAIT_DONE    | draw running, watchdog counting
// CLR_ASSERT   | eng_reset_buff pulse
// CLR_HOLD     | engine held in clear for CLR_CYCLES
// CLR_EXIT     | eng_start pulse to leave clear state
// CLR_SETTLE   | quiet cycle after exit
// COMPLETE     | cmd_done pulse
// HALT         | watchdog fired, waiting for err_clr
module line_cmd_scheduler
  import gpu_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int COORD_W    = COORD_W_DEF,
  parameter int CLR_CYCLES = CLR_CYCLES_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       n_rst,
  line_cmd_scheduler_if.slave        bus,
  input  logic                       err_clr,
  output logic                       busy,
  output logic                       cmd_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);
  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CW4     = 4 * COORD_W;
  localparam int CNT_MAX = (TIMEOUT > CLR_CYCLES) ? TIMEOUT : CLR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] ptr_q, gnt_idx, gid_q;
  logic [NUM_REQ-1:0] gnt;
  logic             accept, sel_clear, wd_expired, hold_last;
  logic [CW4-1:0]   sel_coord;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
  logic             start_q, rbuf_q, busy_q, done_q, terr_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .en      (state_q == S_IDLE),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign accept         = |gnt;
  assign bus.req_ready  = gnt;
  assign wd_expired     = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign hold_last      = (cnt_q == CNT_W'(CLR_CYCLES - 1));

  assign bus.eng_x0         = x0_q;
  assign bus.eng_y0         = y0_q;
  assign bus.eng_x1         = x1_q;
  assign bus.eng_y1         = y1_q;
  assign bus.eng_start      = start_q;
  assign bus.eng_reset_buff = rbuf_q;
  assign busy               = busy_q;
  assign cmd_done           = done_q;
  assign grant_id           = gid_q;
  assign timeout_err        = terr_q;

  // Mux the winning requester's payload.
  always_comb begin
    sel_coord = '0;
    sel_clear = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_coord = bus.req_coord[i*CW4 +: CW4];
        sel_clear = bus.req_clear[i];
      end
    end
  end

  // Next-state logic; eng_done only matters in WAIT_DONE, where it beats the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (accept) state_d = sel_clear ? S_CLR_ASSERT : S_ISSUE;
      S_ISSUE:      state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (bus.eng_done)    state_d = S_COMPLETE;
        else if (wd_expired) state_d = S_HALT;
      end
      S_CLR_ASSERT: state_d = S_CLR_HOLD;
      S_CLR_HOLD:   if (hold_last) state_d = S_CLR_EXIT;
      S_CLR_EXIT:   state_d = S_CLR_SETTLE;
      S_CLR_SETTLE: state_d = S_COMPLETE;
      S_COMPLETE:   state_d = S_IDLE;
      S_HALT:       if (err_clr) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    cnt_d = '0;
    if ((state_d == state_q) && (state_q == S_WAIT_DONE || state_q == S_CLR_HOLD))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // State register and shared watchdog / clear-hold counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered control outputs decoded from the next state so they are glitch-free.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      start_q <= 1'b0;
      rbuf_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      start_q <= (state_d == S_ISSUE) || (state_d == S_CLR_EXIT);
      rbuf_q  <= (state_d == S_CLR_ASSERT);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_COMPLETE);
      if (state_q == S_WAIT_DONE && state_d == S_HALT)
        terr_q <= 1'b1;
      else if (state_q == S_HALT && err_clr)
        terr_q <= 1'b0;
    end
  end

  // Payload latch, grant id and round-robin pointer update on acceptance.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x0_q  <= '0;
      y0_q  <= '0;
      x1_q  <= '0;
      y1_q  <= '0;
      gid_q <= '0;
      ptr_q <= '0;
    end else if (accept) begin
      x0_q  <= sel_coord[CW4-1 -: COORD_W];
      y0_q  <= sel_coord[3*COORD_W-1 -: COORD_W];
      x1_q  <= sel_coord[2*COORD_W-1 -: COORD_W];
      y1_q  <= sel_coord[COORD_W-1:0];
      gid_q <= gnt_idx;
      ptr_q <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end
endmodule
